// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler
// Shares one sequential shift-and-add-3 (double-dabble) binary-to-BCD engine
// among NREQ calendar fields. A round-robin pointer picks the requester.
// The engine then runs 8 shift iterations and returns a one-cycle ack
// together with the 3-digit BCD result.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for any req; grants round-robin from ptr on exit
//  SHIFT | one add-3/shift iteration per cycle, 8 iterations total
//  DONE  | one cycle: ack[grant] high, bcd_out/bcd_id valid, ptr advances
module bcd_conv_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   bin_in,
    output logic [NREQ-1:0]     ack,
    output logic [11:0]         bcd_out,
    output logic [IDW-1:0]      bcd_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  grant;
    logic [2:0]      cnt;
    logic [11:0]     dig;
    logic [7:0]      shreg;

    logic            gnt_valid;
    logic            found_hi;
    logic [IDW-1:0]  hi_idx;
    logic [IDW-1:0]  lo_idx;
    logic [IDW-1:0]  gnt_idx;
    logic [7:0]      sel_bin;
    logic [NREQ-1:0] grant_oh;
    logic [IDW-1:0]  ptr_next;
    logic [11:0]     adj;
    logic [19:0]     shifted;
    logic [11:0]     nxt_dig;
    logic [7:0]      nxt_sh;

    // Round-robin pick: lowest set req at or above ptr, else lowest set req
    // overall (which necessarily sits below ptr, giving the wrap).
    always_comb begin
        gnt_valid = |req;
        found_hi  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDW'(i);
                if (IDW'(i) >= ptr) begin
                    found_hi = 1'b1;
                    hi_idx   = IDW'(i);
                end
            end
        end
        gnt_idx = found_hi ? hi_idx : lo_idx;
    end

    // Select the granted requester's binary value.
    always_comb begin
        sel_bin = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_bin = bin_in[8*i +: 8];
            end
        end
    end

    // One-hot decode of the active grant, and the pointer value after it.
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_oh[i] = (grant == IDW'(i));
        end
        ptr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
    end

    // Double-dabble step: correct each nibble >= 5 by +3, then shift the
    // digit/binary pair left so the binary MSB enters ones[0].
    always_comb begin
        adj[3:0]   = (dig[3:0]   >= 4'd5) ? dig[3:0]   + 4'd3 : dig[3:0];
        adj[7:4]   = (dig[7:4]   >= 4'd5) ? dig[7:4]   + 4'd3 : dig[7:4];
        adj[11:8]  = (dig[11:8]  >= 4'd5) ? dig[11:8]  + 4'd3 : dig[11:8];
        shifted    = {adj, shreg} << 1;
        nxt_dig    = shifted[19:8];
        nxt_sh     = shifted[7:0];
    end

    assign busy = (state != IDLE);

    // Scheduler FSM with registered ack and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            grant   <= '0;
            cnt     <= '0;
            dig     <= '0;
            shreg   <= '0;
            ack     <= '0;
            bcd_out <= '0;
            bcd_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        shreg <= sel_bin;
                        dig   <= '0;
                        cnt   <= '0;
                        grant <= gnt_idx;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    dig   <= nxt_dig;
                    shreg <= nxt_sh;
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        bcd_out <= nxt_dig;
                        bcd_id  <= grant;
                        ack     <= grant_oh;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    ack   <= '0;
                    ptr   <= ptr_next;
                    state <= IDLE;
                end
                default: begin
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed testbench for bcd_conv_scheduler (NREQ=4, IDW=2).
module tb_bcd_conv_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] bin_in;
    logic [3:0]  ack;
    logic [11:0] bcd_out;
    logic [1:0]  bcd_id;
    logic        busy;

    int checks;
    int errors;

    bcd_conv_scheduler #(.NREQ(4), .IDW(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .bin_in  (bin_in),
        .ack     (ack),
        .bcd_out (bcd_out),
        .bcd_id  (bcd_id),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step negedges until ack is seen; n = negedges consumed (bounded).
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0 && n < 40);
    endtask

    // Single isolated conversion on requester idx; call at a negedge in IDLE.
    task automatic run_conv(input string tag, input int idx, input logic [7:0] val,
                            input logic [11:0] exp_bcd);
        int n;
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        bin_in[8*idx +: 8] = val;
        req = oh;
        @(negedge clk);
        check({tag, "_busy"}, busy, 1'b1);
        req = 4'b0;
        wait_ack(n);
        check({tag, "_lat"}, n + 1, 9);
        check({tag, "_ack"}, ack, oh);
        check({tag, "_bcd"}, bcd_out, exp_bcd);
        check({tag, "_id"}, bcd_id, idx);
        @(negedge clk);
        check({tag, "_ack0"}, ack, 4'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        logic [3:0]  exp_ack [5];
        logic [11:0] exp_bcd [5];
        checks = 0;
        errors = 0;
        req    = 4'b0;
        bin_in = 32'b0;
        rst    = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_ack", ack, 4'b0);
        check("rst_bcd", bcd_out, 12'h000);
        check("rst_id", bcd_id, 2'd0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_conv("single59", 0, 8'd59, 12'h059);

        run_conv("b0", 2, 8'd0, 12'h000);
        run_conv("b255", 2, 8'd255, 12'h255);
        run_conv("b99", 2, 8'd99, 12'h099);
        run_conv("b100", 2, 8'd100, 12'h100);

        // Fairness: ptr is 3 after requester 2, so 3 wins before 0.
        bin_in = {8'd42, 8'd0, 8'd0, 8'd7};
        req = 4'b1001;
        wait_ack(n);
        check("fair1_lat", n, 9);
        check("fair1_ack", ack, 4'b1000);
        check("fair1_id", bcd_id, 2'd3);
        check("fair1_bcd", bcd_out, 12'h042);
        wait_ack(n);
        check("fair2_lat", n, 10);
        check("fair2_ack", ack, 4'b0001);
        check("fair2_id", bcd_id, 2'd0);
        check("fair2_bcd", bcd_out, 12'h007);
        req = 4'b0;
        repeat (2) @(negedge clk);

        // bin_in change after the grant edge must not affect the result.
        bin_in[15:8] = 8'd200;
        req = 4'b0010;
        @(negedge clk);
        bin_in[15:8] = 8'd13;
        req = 4'b0;
        wait_ack(n);
        check("stim_ack", ack, 4'b0010);
        check("stim_bcd", bcd_out, 12'h200);
        repeat (2) @(negedge clk);

        // All four held from reset: 0,1,2,3,0 spaced 10 cycles.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bin_in = {8'd44, 8'd33, 8'd22, 8'd11};
        req = 4'b1111;
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_bcd = '{12'h011, 12'h022, 12'h033, 12'h044, 12'h011};
        for (int k = 0; k < 5; k++) begin
            wait_ack(n);
            check($sformatf("rr%0d_lat", k), n, 9);
            check($sformatf("rr%0d_ack", k), ack, exp_ack[k]);
            check($sformatf("rr%0d_id", k), bcd_id, (k % 4));
            check($sformatf("rr%0d_bcd", k), bcd_out, exp_bcd[k]);
            @(negedge clk);
            check($sformatf("rr%0d_ack0", k), ack, 4'b0);
            if (k == 4) req = 4'b0;
        end
        repeat (2) @(negedge clk);

        // Async reset in the 4th SHIFT cycle.
        bin_in[7:0] = 8'd77;
        req = 4'b0001;
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_ack", ack, 4'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_bcd", bcd_out, 12'h000);
        check("arst_id", bcd_id, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_ack(n);
        check("post_lat", n, 9);
        check("post_ack", ack, 4'b0001);
        check("post_bcd", bcd_out, 12'h077);
        req = 4'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
